// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU and the ALU decoder: the 3-bit
//            operation encoding and a helper to extract the B-invert bit.
// Contents : ALU_CTL_W   - width of the alucontrol field
//            alu_op_t    - enumerated operation codes
//            op_inverts_b- 1 when the op complements B and injects carry-in
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int unsigned ALU_CTL_W = 3;

  typedef enum logic [ALU_CTL_W-1:0] {
    ALU_AND    = 3'b000,
    ALU_OR     = 3'b001,
    ALU_ADD    = 3'b010,
    ALU_SLTU_B = 3'b011,
    ALU_ANDN   = 3'b100,
    ALU_ORN    = 3'b101,
    ALU_SUB    = 3'b110,
    ALU_SLT    = 3'b111
  } alu_op_t;

  // Bit 2 of the opcode both inverts B and supplies the +1 carry-in, which
  // turns the adder into a subtractor (two's complement negate of B).
  function automatic logic op_inverts_b(input alu_op_t op);
    return op[2];
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_adder.sv
`default_nettype none
// ============================================================================
// Module   : alu_adder
// Purpose  : N-bit adder with carry-in, shared by the ADD/SUB/SLT paths.
//            Result wraps modulo 2^N; no carry-out is produced.
// Ports    : a, b  (in,  N) - addends
//            cin   (in,  1) - carry-in
//            sum   (out, N) - a + b + cin, modulo 2^N
// Revision : 1.0 - initial release
// ============================================================================
module alu_adder
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum
);

  assign sum = a + b + {{(N-1){1'b0}}, cin};

endmodule : alu_adder
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : N-bit MIPS-style arithmetic/logic unit. Produces a combinational
//            result and zero flag, plus a registered copy of both.
// Ports    : srca       (in,  N) - operand A
//            srcb       (in,  N) - operand B
//            alucontrol (in,  3) - operation select (alu_op_t)
//            aluout     (out, N) - combinational result
//            zero       (out, 1) - combinational, 1 when aluout == 0
//            clk        (in,  1) - rising-edge clock for the output register
//            reset      (in,  1) - synchronous active-high clear of the register
//            aluout_q   (out, N) - aluout registered
//            zero_q     (out, 1) - zero registered
// Revision : 1.0 - initial release
// ============================================================================
module alu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]         srca,
  input  logic [N-1:0]         srcb,
  input  logic [ALU_CTL_W-1:0] alucontrol,
  output logic [N-1:0]         aluout,
  output logic                 zero,
  input  logic                 clk,
  input  logic                 reset,
  output logic [N-1:0]         aluout_q,
  output logic                 zero_q
);

  alu_op_t      w_op;
  logic         w_invb;
  logic [N-1:0] w_bb;
  logic [N-1:0] w_sum;

  assign w_op   = alu_op_t'(alucontrol);
  assign w_invb = op_inverts_b(w_op);
  assign w_bb   = w_invb ? ~srcb : srcb;

  // Single shared adder: ~B + 1 gives subtraction for SUB and SLT.
  alu_adder #(
    .N (N)
  ) u_adder (
    .a   (srca),
    .b   (w_bb),
    .cin (w_invb),
    .sum (w_sum)
  );

  // Both SLT forms take the sign bit of the wrapped sum with no overflow
  // correction; the 011 form simply sees uncomplemented B.
  always_comb begin
    aluout = '0;
    case (w_op)
      ALU_AND, ALU_ANDN:    aluout = srca & w_bb;
      ALU_OR,  ALU_ORN:     aluout = srca | w_bb;
      ALU_ADD, ALU_SUB:     aluout = w_sum;
      ALU_SLTU_B, ALU_SLT:  aluout = {{(N-1){1'b0}}, w_sum[N-1]};
      default:              aluout = '0;
    endcase
  end

  assign zero = ~|aluout;

  // Reset clears the result and sets the flag so the pair stays consistent.
  always_ff @(posedge clk) begin
    if (reset) begin
      aluout_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      aluout_q <= aluout;
      zero_q   <= zero;
    end
  end

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Purpose  : Self-checking bench for alu at N=4: directed vectors, exhaustive
//            combinational sweep, and a randomized registered-path stream
//            with mid-stream reset, all against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] srca;
  logic [N-1:0] srcb;
  logic [2:0]   alucontrol;
  logic [N-1:0] aluout;
  logic         zero;
  logic [N-1:0] aluout_q;
  logic         zero_q;

  int total;
  int bad;

  alu #(
    .N (N)
  ) dut (
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .aluout     (aluout),
    .zero       (zero),
    .clk        (clk),
    .reset      (reset),
    .aluout_q   (aluout_q),
    .zero_q     (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the opcode meanings with plain integer math.
  function automatic logic [3:0] ref_alu(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = a & b;
      1:       r = a | b;
      2:       r = (a + b) % 16;
      3:       r = (((a + b) % 16) >= 8) ? 1 : 0;
      4:       r = a & (15 - b);
      5:       r = a | (15 - b);
      6:       r = (a - b + 16) % 16;
      7:       r = (((a - b + 16) % 16) >= 8) ? 1 : 0;
      default: r = 0;
    endcase
    return r[3:0];
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, then check combinational outputs.
  task automatic apply_comb(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] op, input logic [3:0] exp_out,
                            input logic exp_zero);
    @(negedge clk);
    srca = a; srcb = b; alucontrol = op;
    #1;
    check({tag, ".out"}, aluout, exp_out);
    check({tag, ".zero"}, {3'b000, zero}, {3'b000, exp_zero});
  endtask

  initial begin
    logic [3:0] ea;
    logic [3:0] eb;
    logic [2:0] eop;
    logic [3:0] m;
    logic       rst_now;

    total = 0;
    bad   = 0;
    reset = 1'b0;
    srca = '0; srcb = '0; alucontrol = '0;

    // ---- registered path: reset for two edges ----
    @(negedge clk);
    reset = 1'b1;
    srca = 4'b0101; srcb = 4'b0011; alucontrol = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    check("rst.q", aluout_q, 4'b0000);
    check("rst.zq", {3'b000, zero_q}, 4'b0001);
    check("rst.comb", aluout, 4'b1000);

    // release reset; ADD visible immediately, registered one edge later
    @(negedge clk);
    reset = 1'b0;
    srca = 4'b0101; srcb = 4'b0011; alucontrol = 3'b010;
    #1;
    check("cap.comb", aluout, 4'b1000);
    check("cap.hold", aluout_q, 4'b0000);
    @(posedge clk); #1;
    check("cap.q", aluout_q, 4'b1000);
    check("cap.zq", {3'b000, zero_q}, 4'b0000);

    // ---- directed combinational vectors ----
    apply_comb("add1",  4'b0101, 4'b0011, 3'b010, 4'b1000, 1'b0);
    apply_comb("addw",  4'b1111, 4'b0001, 3'b010, 4'b0000, 1'b1);
    apply_comb("sub0",  4'b0011, 4'b0011, 3'b110, 4'b0000, 1'b1);
    apply_comb("subn",  4'b0010, 4'b0101, 3'b110, 4'b1101, 1'b0);
    apply_comb("and",   4'b1100, 4'b1010, 3'b000, 4'b1000, 1'b0);
    apply_comb("or",    4'b1100, 4'b1010, 3'b001, 4'b1110, 1'b0);
    apply_comb("andn",  4'b1100, 4'b1010, 3'b100, 4'b0100, 1'b0);
    apply_comb("orn",   4'b1100, 4'b1010, 3'b101, 4'b1101, 1'b0);
    apply_comb("and0",  4'b0000, 4'b1111, 3'b000, 4'b0000, 1'b1);
    apply_comb("slt1",  4'b1110, 4'b0001, 3'b111, 4'b0001, 1'b0);
    apply_comb("slt0",  4'b0001, 4'b1110, 3'b111, 4'b0000, 1'b1);
    apply_comb("sltov", 4'b0111, 4'b1000, 3'b111, 4'b0001, 1'b0);
    apply_comb("sltub", 4'b0110, 4'b0011, 3'b011, 4'b0001, 1'b0);

    // ---- exhaustive sweep: 8 ops x 256 operand pairs ----
    for (int op = 0; op < 8; op++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          srca = 4'(a); srcb = 4'(b); alucontrol = 3'(op);
          #1;
          m = ref_alu(a, b, op);
          check($sformatf("sw.o%0d.a%0d.b%0d", op, a, b), aluout, m);
          check($sformatf("sw.z%0d.a%0d.b%0d", op, a, b), {3'b000, zero},
                {3'b000, (m == 4'b0000)});
        end
      end
    end

    // ---- randomized registered stream with occasional reset ----
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ea  = 4'($urandom_range(0, 15));
      eb  = 4'($urandom_range(0, 15));
      eop = 3'($urandom_range(0, 7));
      rst_now = (i == 20) || (i == 21) || (i == 45);
      reset = rst_now;
      srca = ea; srcb = eb; alucontrol = eop;
      m = ref_alu(int'(ea), int'(eb), int'(eop));
      #1;
      check($sformatf("rnd%0d.comb", i), aluout, m);
      @(posedge clk); #1;
      if (rst_now) begin
        check($sformatf("rnd%0d.rq", i), aluout_q, 4'b0000);
        check($sformatf("rnd%0d.rzq", i), {3'b000, zero_q}, 4'b0001);
      end else begin
        check($sformatf("rnd%0d.q", i), aluout_q, m);
        check($sformatf("rnd%0d.zq", i), {3'b000, zero_q}, {3'b000, (m == 4'b0000)});
      end
    end

    @(negedge clk);
    reset = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu
`default_nettype wire
